irq_priority_ctrl: RTL

IRQ_PRIORITY_CTRL -- requirements
Module: irq_priority_ctrl

---
 rtl/irq_pkg.sv | 17 +
 rtl/irq_prio_enc.sv | 28 ++
 rtl/irq_priority_ctrl.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/irq_pkg.sv
// Shared definitions for the interrupt priority controller: the controller
// state encoding and the default source count / nesting depth.
package irq_pkg;

    // Default number of interrupt sources.
    localparam int IRQ_NUM_SRC_DEF    = 16;
    // Default depth of the in-service stack (used when nesting is built in).
    localparam int IRQ_NEST_DEPTH_DEF = 4;

    // Controller states.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_SERVICE = 2'd2
    } irq_state_t;

endpackage

// File: rtl/irq_prio_enc.sv
// Lowest-index priority encoder. Index 0 is the highest priority. The valid
// output is high when any request bit is set.
module irq_prio_enc
    import irq_pkg::*;
#(
    parameter int NUM_SRC = IRQ_NUM_SRC_DEF,
    parameter int IDX_W   = $clog2(NUM_SRC)
) (
    input  logic [NUM_SRC-1:0] req,
    output logic               valid,
    output logic [IDX_W-1:0]   idx
);

    // Scan from the top down so the lowest set index is the last one written.
    always_comb begin
        // NOTE: every output gets a value before the loop so no path leaves
        // it unassigned, which would otherwise infer a latch.
        valid = 1'b0;
        idx   = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (req[i]) begin
                valid = 1'b1;
                idx   = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/irq_priority_ctrl.sv
// Interrupt priority controller.
//
// Rising edges on HARDWARE lines latch into the pending register
// (Interrupt_Register). The lowest-index pending source that is enabled in
// MASK wins arbitration. A small FSM raises IRQ_REQ for the winner, and on
// IRQ_ACK latches the index, clears that pending bit, pulses EPCWrite and
// enters service until IRQ_DONE.
//
// Build option: define IRQ_NESTING_EN to enable nested interrupts. A winner
// whose index is below the one currently in service then raises a new
// request while in service. Acknowledged indices are kept on an in-service
// stack of NEST_DEPTH entries. Without the macro there is no stack, and no
// request is raised while in service.
module irq_priority_ctrl
    import irq_pkg::*;
#(
    parameter int NUM_SRC    = IRQ_NUM_SRC_DEF,
    parameter int IDX_W      = $clog2(NUM_SRC),
    parameter int NEST_DEPTH = IRQ_NEST_DEPTH_DEF
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic [NUM_SRC-1:0] HARDWARE,
    input  logic               IRQ_EN,
    input  logic               MASK_WE,
    input  logic [NUM_SRC-1:0] MASK_WDATA,
    input  logic               CLR_EN,
    input  logic [IDX_W-1:0]   CLR_SELECT,
    input  logic               IRQ_ACK,
    input  logic               IRQ_DONE,
    output logic               IRQ_REQ,
    output logic [IDX_W-1:0]   IRQ_IDX,
    output logic               EPCWrite,
    output logic [NUM_SRC-1:0] Interrupt_Register,
    output logic [NUM_SRC-1:0] MASK,
    output logic               in_service
);

    // Reject parameter sets that the index and shift logic cannot represent.
    if (NUM_SRC < 2 || NUM_SRC > 32 || NEST_DEPTH < 1 || IDX_W < $clog2(NUM_SRC)) begin : g_param_check
        $error("irq_priority_ctrl: unsupported NUM_SRC / IDX_W / NEST_DEPTH");
    end

    // A single set bit at position 0, shifted to build one-hot clear masks.
    // A shift past the top bit yields zero, so an out-of-range CLR_SELECT
    // clears nothing.
    localparam logic [NUM_SRC-1:0] ONE_HOT0 = NUM_SRC'(1);

    irq_state_t         state;
    logic [NUM_SRC-1:0] hw_prev;
    logic [NUM_SRC-1:0] hw_edge;
    logic [NUM_SRC-1:0] enabled_src;
    logic [NUM_SRC-1:0] clr_mask;
    logic               win_valid;
    logic [IDX_W-1:0]   win_idx;
    logic               ack_take;
    logic               eligible;

    assign hw_edge     = HARDWARE & ~hw_prev;
    assign enabled_src = Interrupt_Register & MASK;
    assign ack_take    = (state == ST_REQ) && IRQ_ACK;

    // Software clear and acknowledge clear. A new edge on the same bit in
    // the same cycle overrides both, so an edge is never lost.
    assign clr_mask = (CLR_EN   ? (ONE_HOT0 << CLR_SELECT) : '0)
                    | (ack_take ? (ONE_HOT0 << IRQ_IDX)    : '0);

    irq_prio_enc #(
        .NUM_SRC (NUM_SRC),
        .IDX_W   (IDX_W)
    ) u_prio_enc (
        .req   (enabled_src),
        .valid (win_valid),
        .idx   (win_idx)
    );

`ifdef IRQ_NESTING_EN
    localparam int DEPTH_W = $clog2(NEST_DEPTH + 1);

    logic [IDX_W-1:0]   nest_stack [NEST_DEPTH];
    logic [DEPTH_W-1:0] nest_depth;
    logic [IDX_W-1:0]   nest_top;
    logic [IDX_W-1:0]   nest_below;
    logic               nest_full;
    logic               preempt_ok;

    // Read the top-of-stack entry and the entry beneath it.
    always_comb begin
        nest_top   = '0;
        nest_below = '0;
        for (int i = 0; i < NEST_DEPTH; i++) begin
            if (nest_depth == DEPTH_W'(i + 1)) nest_top   = nest_stack[i];
            if (nest_depth == DEPTH_W'(i + 2)) nest_below = nest_stack[i];
        end
    end

    assign nest_full  = (nest_depth == DEPTH_W'(NEST_DEPTH));
    assign preempt_ok = (nest_depth == '0) || (!nest_full && (win_idx < nest_top));
    assign eligible   = IRQ_EN && win_valid && preempt_ok;

    // Push the acknowledged index onto the in-service stack.
    // NOTE: the stack storage has no reset. nest_depth alone says which
    // entries are live, so clearing the array would only cost reset routing.
    always_ff @(posedge CLK) begin
        if (ack_take) begin
            for (int i = 0; i < NEST_DEPTH; i++) begin
                if (nest_depth == DEPTH_W'(i)) nest_stack[i] <= IRQ_IDX;
            end
        end
    end
`else
    assign eligible = IRQ_EN && win_valid;
`endif

    // Edge-detect history and the pending register.
    always_ff @(posedge CLK) begin
        // NOTE: sequential state uses non-blocking assignments, so every
        // register here sees the pre-edge values of the others.
        if (RESET) begin
            hw_prev            <= '0;
            Interrupt_Register <= '0;
        end else begin
            hw_prev            <= HARDWARE;
            Interrupt_Register <= (Interrupt_Register & ~clr_mask) | hw_edge;
        end
    end

    // Mask register. Writing it never touches the pending bits.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            MASK <= '0;
        end else if (MASK_WE) begin
            MASK <= MASK_WDATA;
        end
    end

    // Request / acknowledge / service FSM with registered outputs.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state      <= ST_IDLE;
            IRQ_REQ    <= 1'b0;
            IRQ_IDX    <= '0;
            EPCWrite   <= 1'b0;
            in_service <= 1'b0;
`ifdef IRQ_NESTING_EN
            nest_depth <= '0;
`endif
        end else begin
            EPCWrite <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (eligible) begin
                        state   <= ST_REQ;
                        IRQ_REQ <= 1'b1;
                        IRQ_IDX <= win_idx;
                    end
                end

                ST_REQ: begin
                    if (IRQ_ACK) begin
                        state      <= ST_SERVICE;
                        IRQ_REQ    <= 1'b0;
                        EPCWrite   <= 1'b1;
                        in_service <= 1'b1;
`ifdef IRQ_NESTING_EN
                        nest_depth <= nest_depth + DEPTH_W'(1);
`endif
                    end else if (eligible) begin
                        IRQ_IDX <= win_idx;
                    end else begin
                        IRQ_REQ <= 1'b0;
`ifdef IRQ_NESTING_EN
                        // A withdrawn preemption falls back to the
                        // interrupt that was already in service.
                        if (nest_depth != '0) begin
                            state      <= ST_SERVICE;
                            in_service <= 1'b1;
                            IRQ_IDX    <= nest_top;
                        end else begin
                            state <= ST_IDLE;
                        end
`else
                        state <= ST_IDLE;
`endif
                    end
                end

                ST_SERVICE: begin
`ifdef IRQ_NESTING_EN
                    if (IRQ_DONE) begin
                        nest_depth <= nest_depth - DEPTH_W'(1);
                        if (nest_depth == DEPTH_W'(1)) begin
                            state      <= ST_IDLE;
                            in_service <= 1'b0;
                        end else begin
                            IRQ_IDX <= nest_below;
                        end
                    end else if (eligible) begin
                        state      <= ST_REQ;
                        IRQ_REQ    <= 1'b1;
                        in_service <= 1'b0;
                        IRQ_IDX    <= win_idx;
                    end
`else
                    if (IRQ_DONE) begin
                        state      <= ST_IDLE;
                        in_service <= 1'b0;
                    end
`endif
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
